// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - RTC multiplexed address/data bus master; optional feature macro RTC_ADDR_SKIP_EN
module rtc_bus_ctrl #(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 8,
    parameter int T_HOLD   = 2,
    parameter int T_GAP    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    inout  wire  [7:0] datRTC,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR
);

    // Counter reload values: a timed state lasts T_x cycles, exiting when the count hits zero.
    localparam logic [7:0] LD_SETUP  = 8'(T_SETUP - 1);
    localparam logic [7:0] LD_STROBE = 8'(T_STROBE - 1);
    localparam logic [7:0] LD_HOLD   = 8'(T_HOLD - 1);
    localparam logic [7:0] LD_GAP    = 8'(T_GAP - 1);

    typedef enum logic [3:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        GAP,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       cnt_zero;

    // Request latched when start is accepted; the pins are driven from these, never from live inputs.
    logic       req_rw;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;

    // Registered bus driver.
    logic       drive_en;
    logic [7:0] bus_q;

    // State groupings used by the pin decode.
    logic       in_addr_cyc;
    logic       in_data_cyc;
    logic       rd_strobe;
    logic       skip_addr;

`ifdef RTC_ADDR_SKIP_EN
    logic [7:0] last_addr;
    logic       last_valid;

    assign skip_addr = last_valid && (addr == last_addr);
`else
    assign skip_addr = 1'b0;
`endif

    assign cnt_zero    = (cnt == 8'd0);
    assign in_addr_cyc = (state == A_SETUP) || (state == A_STROBE) || (state == A_HOLD);
    assign in_data_cyc = (state == D_SETUP) || (state == D_STROBE) || (state == D_HOLD);
    assign rd_strobe   = (state == D_STROBE) && req_rw;

    // The controller only drives the shared bus through this registered enable.
    assign datRTC = drive_en ? bus_q : 8'bz;

    // Sequencer plus registered pin decode; pins follow the state one clock later, so no decode glitches reach the RTC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            req_rw    <= 1'b0;
            req_addr  <= 8'd0;
            req_wdata <= 8'd0;
            drive_en  <= 1'b0;
            bus_q     <= 8'd0;
            CS        <= 1'b1;
            AD        <= 1'b1;
            RD        <= 1'b1;
            WR        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= 8'd0;
`ifdef RTC_ADDR_SKIP_EN
            last_addr  <= 8'd0;
            last_valid <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // busy is still high during the visible done cycle, so a start there is dropped.
                    if (start && !busy) begin
                        req_rw    <= rw;
                        req_addr  <= addr;
                        req_wdata <= wdata;
                        cnt       <= LD_SETUP;
                        state     <= skip_addr ? D_SETUP : A_SETUP;
                    end
                end
                A_SETUP: begin
                    if (cnt_zero) begin
                        state <= A_STROBE;
                        cnt   <= LD_STROBE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                A_STROBE: begin
                    if (cnt_zero) begin
                        state <= A_HOLD;
                        cnt   <= LD_HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                A_HOLD: begin
                    if (cnt_zero) begin
                        state <= GAP;
                        cnt   <= LD_GAP;
`ifdef RTC_ADDR_SKIP_EN
                        last_addr  <= req_addr;
                        last_valid <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        state <= D_SETUP;
                        cnt   <= LD_SETUP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                D_SETUP: begin
                    if (cnt_zero) begin
                        state <= D_STROBE;
                        cnt   <= LD_STROBE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                D_STROBE: begin
                    if (cnt_zero) begin
                        state <= D_HOLD;
                        cnt   <= LD_HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                D_HOLD: begin
                    if (cnt_zero) begin
                        state <= DONE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase

            CS       <= !((state == A_STROBE) || (state == D_STROBE));
            WR       <= !((state == A_STROBE) || ((state == D_STROBE) && !req_rw));
            RD       <= !rd_strobe;
            AD       <= !in_addr_cyc;
            drive_en <= in_addr_cyc || (in_data_cyc && !req_rw);
            bus_q    <= in_addr_cyc ? req_addr : req_wdata;
            busy     <= (state != IDLE);
            done     <= (state == DONE);

            // Capture on the edge that ends the last RD-low cycle, while the RTC is still driving.
            if (!RD && !rd_strobe) begin
                rdata <= datRTC;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb/tb_rtc_bus_ctrl.sv - scoreboard bench for rtc_bus_ctrl with a behavioural RTC bus model
module tb_rtc_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    wire  [7:0] datRTC;
    logic       CS;
    logic       AD;
    logic       RD;
    logic       WR;

    rtc_bus_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rw     (rw),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done),
        .datRTC (datRTC),
        .CS     (CS),
        .AD     (AD),
        .RD     (RD),
        .WR     (WR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RTC model: latches the address on address strobes, stores on write strobes, drives on read strobes.
    logic [7:0] mem [256];
    logic [7:0] rtc_addr = 8'd0;
    logic       probe_en = 1'b0;
    logic [7:0] probe_val = 8'd0;
    wire        rtc_en = !CS && !RD && AD;

    assign datRTC = rtc_en ? mem[rtc_addr] : (probe_en ? probe_val : 8'bz);

    always @(negedge clk) begin
        if (!CS && !WR) begin
            if (!AD) rtc_addr <= datRTC;
            else     mem[rtc_addr] <= datRTC;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int         k_done;
        int         a_cyc;
        logic [7:0] a_val;
        logic [7:0] d_val;
        logic       is_rd;
        logic [7:0] rdata;
    } exp_t;

    exp_t q[$];
    int   n_done = 0;
    int   n_push = 0;

    // Monitor: accumulates the bus trace of the current transaction and scores it when done appears.
    int         a_cnt = 0;
    int         d_cnt = 0;
    int         hz = 0;
    logic [7:0] a_val = 8'd0;
    logic [7:0] d_val = 8'd0;
    logic       busy_chk = 1'b0;
    logic [7:0] rdata_ref = 8'd0;
    logic       prev_cs = 1'b1;
    logic       prev_ad = 1'b1;
    logic [7:0] prev_bus = 8'd0;
    exp_t       me;

    always @(negedge clk) begin
        if (reset) begin
            a_cnt = 0;
            d_cnt = 0;
            hz = 0;
            busy_chk = 1'b0;
            rdata_ref = 8'd0;
        end else begin
            if (busy_chk) begin
                check("busy_fall_after_done", busy, 0);
                busy_chk = 1'b0;
            end
            if (!CS && !prev_cs && ((AD != prev_ad) || (datRTC != prev_bus))) hz++;
            if (!CS && !AD && !WR && RD) begin
                a_cnt++;
                a_val = datRTC;
            end
            if (!CS && AD && (RD ^ WR)) begin
                d_cnt++;
                d_val = datRTC;
            end
            if (done) begin
                n_done++;
                check("queue_nonempty_at_done", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    me = q.pop_front();
                    check("done_cycle", cyc, me.k_done);
                    check("addr_strobe_cycles", a_cnt, me.a_cyc);
                    if (me.a_cyc > 0) check("addr_bus_value", a_val, me.a_val);
                    check("data_strobe_cycles", d_cnt, 8);
                    check("data_bus_value", d_val, me.d_val);
                    check("no_change_while_cs_low", hz, 0);
                    if (me.is_rd) rdata_ref = me.rdata;
                    check("rdata_at_done", rdata, rdata_ref);
                end
                busy_chk = 1'b1;
                a_cnt = 0;
                d_cnt = 0;
                hz = 0;
            end
        end
        prev_cs  = CS;
        prev_ad  = AD;
        prev_bus = datRTC;
    end

    // Address-skip model: any address cycle that completes makes the next same-address access skip.
    logic [7:0] sk_addr = 8'd0;
    logic       sk_valid = 1'b0;

    task automatic idle_check(input string tag);
        probe_en  = 1'b1;
        probe_val = 8'h00;
        #1;
        check({tag, "_CS"}, CS, 1);
        check({tag, "_RD"}, RD, 1);
        check({tag, "_WR"}, WR, 1);
        check({tag, "_AD"}, AD, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bus_released"}, datRTC, 8'h00);
        probe_en = 1'b0;
    endtask

    // One transaction: push the expectation, pulse start, wait (bounded) for the monitor to see done.
    task automatic txn(input logic r, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input bit dup, input bit hold_after);
        exp_t e;
        int   k;
        int   n0;
        bit   skip;
        @(negedge clk);
        #1;
        k = cyc + 1;
        skip = 1'b0;
`ifdef RTC_ADDR_SKIP_EN
        skip = sk_valid && (a == sk_addr);
`endif
        e.k_done = k + (skip ? 13 : 29);
        e.a_cyc  = skip ? 0 : 8;
        e.a_val  = a;
        e.d_val  = r ? exp_rd : wd;
        e.is_rd  = r;
        e.rdata  = exp_rd;
        q.push_back(e);
        n_push++;
        sk_addr  = a;
        sk_valid = 1'b1;
        n0 = n_done;
        rw = r;
        addr = a;
        wdata = wd;
        start = 1'b1;
        for (int i = 0; i < 60 && n_done == n0; i++) begin
            @(negedge clk);
            #1;
            start = (dup && cyc == k + 4);
        end
        start = 1'b0;
        check("done_within_budget", n_done, n0 + 1);
        if (hold_after) begin
            rw = 1'b0;
            addr = 8'h77;
            wdata = 8'hEE;
            start = 1'b1;
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        idle_check("reset_idle");
        check("reset_rdata", rdata, 8'h00);

        // Write 0x5A to 0x21, with a stray start at k+5 that must be ignored.
        txn(1'b0, 8'h21, 8'h5A, 8'h00, 1'b1, 1'b0);
        check("model_reg_21_after_write", mem[8'h21], 8'h5A);
        repeat (2) @(negedge clk);
        idle_check("post_write_idle");

        // Read 0x21; a start held into the done cycle must be dropped.
        txn(1'b1, 8'h21, 8'h81, 8'h5A, 1'b0, 1'b1);

        // Accepted in the first idle cycle after done.
        txn(1'b0, 8'h22, 8'hC3, 8'h00, 1'b0, 1'b0);
        check("model_reg_22_after_write", mem[8'h22], 8'hC3);
        check("model_reg_77_untouched", mem[8'h77], 8'h00);

        // Read of 0x21 interrupted by reset in the middle of its data strobe.
        @(negedge clk);
        #1;
        k = cyc + 1;
        rw = 1'b1;
        addr = 8'h21;
        wdata = 8'h81;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 40 && cyc < k + 22; i++) @(negedge clk);
        #1;
        check("read_strobe_active_before_reset", RD, 0);
        reset = 1'b1;
        sk_valid = 1'b0;
        probe_en = 1'b1;
        probe_val = 8'h00;
        #1;
        check("midreset_CS", CS, 1);
        check("midreset_RD", RD, 1);
        check("midreset_busy", busy, 0);
        check("midreset_rdata", rdata, 8'h00);
        check("midreset_bus_released", datRTC, 8'h00);
        probe_en = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;

        txn(1'b1, 8'h22, 8'h81, 8'hC3, 1'b0, 1'b0);

        // Same address back to back, then a different one.
        txn(1'b0, 8'h21, 8'h99, 8'h00, 1'b0, 1'b0);
        txn(1'b1, 8'h21, 8'h81, 8'h99, 1'b0, 1'b0);
        txn(1'b1, 8'h22, 8'h81, 8'hC3, 1'b0, 1'b0);

        repeat (40) @(negedge clk);
        check("all_expected_dones_seen", q.size(), 0);
        check("done_count", n_done, n_push);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
